// File: rtl/gps_msg_timing.sv
// gps_msg_timing: chip/epoch/bit timing generator and MSB-first navigation
// message serialiser feeding gps_gen_core (chip strobe -> ena_in, bit -> msg_in).
module gps_msg_timing #(
    parameter int         CLK_PER_CHIP    = 16,
    parameter int         CHIPS_PER_EPOCH = 1023,
    parameter int         EPOCHS_PER_BIT  = 20,
    parameter logic [7:0] PRESET_WORD     = 8'h8B
) (
    input  logic       clk_in,
    input  logic       rst_in_n,
    input  logic       run_in,
    input  logic       use_msg_preset_in,
    input  logic [7:0] msg_data_in,
    input  logic       msg_valid_in,
    output logic       msg_ready_out,
    output logic       chip_ena_out,
    output logic       epoch_out,
    output logic       bit_edge_out,
    output logic       msg_bit_out,
    output logic       underrun_out
);

    localparam int DIV_W   = (CLK_PER_CHIP    > 1) ? $clog2(CLK_PER_CHIP)    : 1;
    localparam int CHIP_W  = (CHIPS_PER_EPOCH > 1) ? $clog2(CHIPS_PER_EPOCH) : 1;
    localparam int EPOCH_W = (EPOCHS_PER_BIT  > 1) ? $clog2(EPOCHS_PER_BIT)  : 1;

    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(CLK_PER_CHIP - 1);
    localparam logic [CHIP_W-1:0]  CHIP_LAST  = CHIP_W'(CHIPS_PER_EPOCH - 1);
    localparam logic [EPOCH_W-1:0] EPOCH_LAST = EPOCH_W'(EPOCHS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [DIV_W-1:0]   div_cnt;
    logic [CHIP_W-1:0]  chip_cnt;
    logic [EPOCH_W-1:0] epoch_cnt;
    logic [7:0]         shift_reg;
    logic [2:0]         bit_idx;
    logic [7:0]         hold_data;
    logic               hold_full;

    logic       in_run;
    logic       chip_ena;
    logic       epoch;
    logic       bit_edge;
    logic       load_now;
    logic       take_hold;
    logic       accept;
    logic [7:0] load_word;

    // Strobes are decoded straight from the registered counters so they
    // vanish the instant the state register leaves RUN (including async reset).
    assign in_run   = (state == RUN);
    assign chip_ena = in_run & (div_cnt == DIV_LAST);
    assign epoch    = chip_ena & (chip_cnt == CHIP_LAST);
    assign bit_edge = epoch & (epoch_cnt == EPOCH_LAST);

    // A byte is fetched in LOAD and at the edge closing the eighth bit.
    // Dropping run_in wins over a load so a queued byte is never consumed
    // on the way back to IDLE.
    assign load_now  = run_in & ((state == LOAD) | (bit_edge & (bit_idx == 3'd7)));
    assign take_hold = load_now & ~use_msg_preset_in & hold_full;
    assign load_word = (~use_msg_preset_in & hold_full) ? hold_data : PRESET_WORD;
    assign accept    = msg_valid_in & ~hold_full;

    assign chip_ena_out  = chip_ena;
    assign epoch_out     = epoch;
    assign bit_edge_out  = bit_edge;
    assign msg_bit_out   = shift_reg[7];
    assign msg_ready_out = ~hold_full;
    assign underrun_out  = load_now & ~use_msg_preset_in & ~hold_full;

    // State register.
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: run_in low forces IDLE from any state.
    always_comb begin
        state_next = state;
        if (!run_in) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    state_next = LOAD;
                LOAD:    state_next = RUN;
                RUN:     state_next = RUN;
                default: state_next = IDLE;
            endcase
        end
    end

    // Clock divider, chip and epoch counters; cleared whenever we head to IDLE.
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            div_cnt   <= '0;
            chip_cnt  <= '0;
            epoch_cnt <= '0;
        end else if (!run_in) begin
            div_cnt   <= '0;
            chip_cnt  <= '0;
            epoch_cnt <= '0;
        end else if (in_run) begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
            if (chip_ena) begin
                chip_cnt <= (chip_cnt == CHIP_LAST) ? '0 : chip_cnt + CHIP_W'(1);
            end
            if (epoch) begin
                epoch_cnt <= (epoch_cnt == EPOCH_LAST) ? '0 : epoch_cnt + EPOCH_W'(1);
            end
        end
    end

    // Message shift register and bit index; zeroed outside a run so the
    // bit output idles low.
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            shift_reg <= '0;
            bit_idx   <= '0;
        end else if (!run_in) begin
            shift_reg <= '0;
            bit_idx   <= '0;
        end else if (load_now) begin
            shift_reg <= load_word;
            bit_idx   <= '0;
        end else if (bit_edge) begin
            shift_reg <= {shift_reg[6:0], 1'b0};
            bit_idx   <= bit_idx + 3'd1;
        end
    end

    // Holding-register full flag; a write and a consume never coincide
    // because writes are only accepted while empty.
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            hold_full <= 1'b0;
        end else if (accept) begin
            hold_full <= 1'b1;
        end else if (take_hold) begin
            hold_full <= 1'b0;
        end
    end

    // Holding-register payload; only meaningful while hold_full is set.
    always_ff @(posedge clk_in) begin
        if (accept) begin
            hold_data <= msg_data_in;
        end
    end

endmodule

// File: tb/tb_gps_msg_timing.sv
// Bench for gps_msg_timing with a short timing chain (2 clk/chip, 5 chips/epoch,
// 3 epochs/bit). Expected message bits are queued by the stimulus and popped
// by a monitor at every bit edge.
module tb_gps_msg_timing;

    logic       clk_in = 1'b0;
    logic       rst_in_n;
    logic       run_in;
    logic       use_msg_preset_in;
    logic [7:0] msg_data_in;
    logic       msg_valid_in;
    logic       msg_ready_out;
    logic       chip_ena_out;
    logic       epoch_out;
    logic       bit_edge_out;
    logic       msg_bit_out;
    logic       underrun_out;

    gps_msg_timing #(
        .CLK_PER_CHIP    (2),
        .CHIPS_PER_EPOCH (5),
        .EPOCHS_PER_BIT  (3),
        .PRESET_WORD     (8'h8B)
    ) dut (
        .clk_in            (clk_in),
        .rst_in_n          (rst_in_n),
        .run_in            (run_in),
        .use_msg_preset_in (use_msg_preset_in),
        .msg_data_in       (msg_data_in),
        .msg_valid_in      (msg_valid_in),
        .msg_ready_out     (msg_ready_out),
        .chip_ena_out      (chip_ena_out),
        .epoch_out         (epoch_out),
        .bit_edge_out      (bit_edge_out),
        .msg_bit_out       (msg_bit_out),
        .underrun_out      (underrun_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic b;
        logic u;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   underrun_seen = 0;
    logic sb_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    // Monitor: at each bit edge, the bit still on the output belongs to the
    // period that is closing; underrun (if any) fires in that same cycle.
    always @(negedge clk_in) begin
        if (underrun_out === 1'b1) underrun_seen++;
        if (sb_on && bit_edge_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_edge at %0t: got bit %0b, expected no edge", $time, msg_bit_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_msg_bit", msg_bit_out, e.b);
                check("sb_underrun", underrun_out, e.u);
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b, input logic last_udr);
        for (int i = 7; i >= 0; i--) begin
            exp_q.push_back('{b: b[i], u: (i == 0) ? last_udr : 1'b0});
        end
    endtask

    task automatic do_reset();
        sb_on             = 1'b0;
        run_in            = 1'b0;
        use_msg_preset_in = 1'b0;
        msg_valid_in      = 1'b0;
        msg_data_in       = 8'h00;
        rst_in_n          = 1'b0;
        tick();
        tick();
        rst_in_n = 1'b1;
        tick();
    endtask

    task automatic write_byte(input logic [7:0] b);
        int n;
        n = 0;
        while (msg_ready_out !== 1'b1 && n < 500) begin
            tick();
            n++;
        end
        check("write_ready_wait", msg_ready_out, 1'b1);
        msg_data_in  = b;
        msg_valid_in = 1'b1;
        tick();
        msg_valid_in = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("sb_drain_left", exp_q.size(), 0);
    endtask

    // Raise run_in and check LOAD plus ncyc RUN cycles of strobe timing.
    task automatic run_timing(input int ncyc, input logic load_udr);
        run_in = 1'b1;
        tick();
        check("load_chip_ena", chip_ena_out, 1'b0);
        check("load_underrun", underrun_out, load_udr);
        tick();
        for (int n = 1; n <= ncyc; n++) begin
            check("t_chip_ena", chip_ena_out, (n % 2) == 0);
            check("t_epoch", epoch_out, (n % 10) == 0);
            check("t_bit_edge", bit_edge_out, (n % 30) == 0);
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---- reset values ----
        do_reset();
        check("rst_ready", msg_ready_out, 1'b1);
        check("rst_chip_ena", chip_ena_out, 1'b0);
        check("rst_epoch", epoch_out, 1'b0);
        check("rst_bit_edge", bit_edge_out, 1'b0);
        check("rst_msg_bit", msg_bit_out, 1'b0);
        check("rst_underrun", underrun_out, 1'b0);

        // ---- T1: strobe timing, empty holding register underruns at LOAD ----
        run_timing(60, 1'b1);
        run_in = 1'b0;
        tick();

        // ---- T2: C3 queued before run ----
        do_reset();
        write_byte(8'hC3);
        check("t2_ready_full", msg_ready_out, 1'b0);
        push_byte(8'hC3, 1'b1);
        sb_on  = 1'b1;
        run_in = 1'b1;
        tick();
        check("t2_load_ready", msg_ready_out, 1'b0);
        check("t2_load_underrun", underrun_out, 1'b0);
        tick();
        check("t2_run_ready", msg_ready_out, 1'b1);
        drain(400);
        sb_on  = 1'b0;
        run_in = 1'b0;
        tick();

        // ---- T3: seamless second byte, then underrun and preset ----
        do_reset();
        write_byte(8'hA5);
        push_byte(8'hA5, 1'b0);
        push_byte(8'h0F, 1'b1);
        push_byte(8'h8B, 1'b1);
        sb_on  = 1'b1;
        run_in = 1'b1;
        tick();
        tick();
        write_byte(8'h0F);
        check("t3_ready_after_write", msg_ready_out, 1'b0);
        drain(900);
        sb_on  = 1'b0;
        run_in = 1'b0;
        tick();

        // ---- T4: preset overrides queued 55 ----
        do_reset();
        write_byte(8'h55);
        use_msg_preset_in = 1'b1;
        push_byte(8'h8B, 1'b0);
        push_byte(8'h8B, 1'b0);
        begin
            int u0;
            u0     = underrun_seen;
            sb_on  = 1'b1;
            run_in = 1'b1;
            tick();
            check("t4_load_underrun", underrun_out, 1'b0);
            drain(600);
            check("t4_underrun_count", underrun_seen - u0, 0);
            check("t4_ready_held", msg_ready_out, 1'b0);
        end
        sb_on  = 1'b0;
        run_in = 1'b0;
        use_msg_preset_in = 1'b0;
        tick();

        // ---- T5: drop run mid-bit, queued byte survives ----
        do_reset();
        run_in = 1'b1;
        tick();
        tick();
        write_byte(8'h3C);
        check("t5_ready_full", msg_ready_out, 1'b0);
        repeat (43) tick();
        run_in = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("t5_idle_chip_ena", chip_ena_out, 1'b0);
            check("t5_idle_epoch", epoch_out, 1'b0);
            check("t5_idle_bit_edge", bit_edge_out, 1'b0);
            check("t5_idle_msg_bit", msg_bit_out, 1'b0);
            tick();
        end
        check("t5_idle_ready", msg_ready_out, 1'b0);
        push_byte(8'h3C, 1'b1);
        sb_on = 1'b1;
        run_timing(30, 1'b0);
        check("t5_rerun_ready", msg_ready_out, 1'b1);
        drain(400);
        sb_on  = 1'b0;
        run_in = 1'b0;
        tick();

        // ---- T6: asynchronous reset mid-epoch ----
        do_reset();
        run_in = 1'b1;
        tick();
        tick();
        write_byte(8'h77);
        repeat (12) tick();
        check("t6_pre_chip_ena", chip_ena_out, 1'b1);
        check("t6_pre_msg_bit", msg_bit_out, 1'b1);
        check("t6_pre_ready", msg_ready_out, 1'b0);
        #2;
        rst_in_n = 1'b0;
        #1;
        check("t6_async_chip_ena", chip_ena_out, 1'b0);
        check("t6_async_msg_bit", msg_bit_out, 1'b0);
        check("t6_async_epoch", epoch_out, 1'b0);
        check("t6_async_bit_edge", bit_edge_out, 1'b0);
        check("t6_async_underrun", underrun_out, 1'b0);
        check("t6_async_ready", msg_ready_out, 1'b1);
        run_in = 1'b0;
        tick();
        rst_in_n = 1'b1;
        tick();
        check("t6_release_ready", msg_ready_out, 1'b1);
        check("t6_release_msg_bit", msg_bit_out, 1'b0);
        run_in = 1'b1;
        tick();
        check("t6_lost_byte_underrun", underrun_out, 1'b1);
        run_in = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
